add_channel_pipe: RTL
=====================

ADD_CHANNEL_PIPE -- requirements
Module: add_channel_pipe

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: signed width of each input channel value.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: signed width of the result.
REQ-003 SHALL have parameter LANES, default 16: channels per input beat; power of two, at least 2.
REQ-004 SHALL have parameter BEATS, default 4: beats per result; total channels = LANES*BEATS; at least 1.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: in_data holds a beat.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, LANES*BIT_WIDTH: channel k at bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH], signed.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a result.
REQ-011 SHALL have port out_ready, input, 1: consumer takes result.
REQ-012 SHALL have port out_data, output, OUT_WIDTH: signed channel sum.
REQ-013 SHALL have port out_sat, output, 1: out_data was clipped.

Function
REQ-014 SHALL accept a beat on a rising edge with in_valid and in_ready both high.
REQ-015 SHALL reduce each beat in a pairwise adder tree of log2(LANES) levels, each level registered; level n width BIT_WIDTH+n; no internal overflow.
REQ-016 SHALL sum tree outputs in an accumulator of width ACC_W = BIT_WIDTH+clog2(LANES*BEATS); beat 0 of a group loads, later beats add.
REQ-017 SHALL count tree outputs modulo BEATS; on beat BEATS-1 the final sum loads the output register and out_valid is set.
REQ-018 SHALL register out_valid high exactly log2(LANES)+1 cycles after the edge accepting the last beat of a group, with no stall.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready); when low, all tree levels, accumulator, counter and output register hold.
REQ-020 SHALL hold out_data, out_sat and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on out_ready handshake unless a new result loads the same edge, in which case out_valid stays high with new data.
REQ-022 SHALL, with BEATS=1, output each tree result directly as a result (accumulator load only).
REQ-023 SHALL sustain one beat per cycle with out_ready high; in_valid gaps insert bubbles without disturbing partial sums.

Reset
REQ-024 SHALL, when rst_n is low at a rising edge, clear all tree valids, partial sums, accumulator, beat counter, out_valid, out_data and out_sat to 0.
REQ-025 SHALL discard any partially accumulated group on reset mid-operation; the first beat after reset is beat 0.
REQ-026 SHALL drive in_ready high in the cycle after reset release.

Configuration
REQ-027 SHALL, with ADD_CHANNEL_SAT_EN defined, clip ACC_W sum to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set out_sat when clipped.
REQ-028 SHALL, without ADD_CHANNEL_SAT_EN, output the low OUT_WIDTH bits (two's-complement wrap) and tie out_sat to 0.

Structure
REQ-029 SHALL place clog2 function, ACC_W derivation and saturate function in package add_channel_pkg.
REQ-030 SHALL build each tree level from one sub-module add_tree_level (parameters IN_WIDTH, PAIRS; registered pairwise sums with valid and hold enable).

Verification
REQ-031 SHALL cover: defaults, 4 beats all channels = 1 -> out_data=64, out_sat=0, out_valid 5 cycles after last beat.
REQ-032 SHALL cover: defaults, 4 beats all channels = -128 -> out_data=-8192, out_sat=0.
REQ-033 SHALL cover: OUT_WIDTH=12, all channels = 127 -> with macro out_data=2047, out_sat=1; without macro out_data=-64, out_sat=0.
REQ-034 SHALL cover: back-to-back 8 beats, out_ready low 10 cycles from first result -> in_ready low while held, results 64 then 128 (second group all 2) delivered in order, none lost.
REQ-035 SHALL cover: rst_n low one cycle after 2 beats of a group, then 4 beats of value 3 -> single result 192, no stale contribution.
REQ-036 SHALL cover: BEATS=1, LANES=4, beats {1,2,3,4},{-1,-1,-1,-1} -> results 10 then -4 on consecutive cycles.

Source files
------------

// File: rtl/add_channel_pkg.sv
// Shared sizing helpers and the output clipping function for the channel-sum pipeline.
package add_channel_pkg;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Accumulator must hold the full sum of every channel in a group without overflow.
  function automatic int acc_width(input int bit_width, input int lanes, input int beats);
    return bit_width + clog2(lanes * beats);
  endfunction

  function automatic sat_res_t saturate(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_channel_pipe_level.sv
// One registered level of the adder tree: PAIRS adjacent signed inputs summed with one growth bit.
module add_tree_level
  import add_channel_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int PAIRS    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic                           valid_i,
  input  logic [2*PAIRS*IN_WIDTH-1:0]    data_i,
  output logic                           valid_o,
  output logic [PAIRS*(IN_WIDTH+1)-1:0]  data_o
);

  localparam int OW = IN_WIDTH + 1;

  logic valid_q;

  genvar gi;
  for (gi = 0; gi < PAIRS; gi++) begin : g_pair
    logic signed [IN_WIDTH-1:0] a;
    logic signed [IN_WIDTH-1:0] b;
    logic signed [OW-1:0]       sum_d;
    logic signed [OW-1:0]       sum_q;

    assign a     = data_i[2*gi*IN_WIDTH +: IN_WIDTH];
    assign b     = data_i[(2*gi+1)*IN_WIDTH +: IN_WIDTH];
    assign sum_d = OW'(a) + OW'(b);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_q <= '0;
      end else if (en_i && valid_i) begin
        sum_q <= sum_d;
      end
    end

    assign data_o[gi*OW +: OW] = sum_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
    end
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/add_channel_pipe.sv
// Sums LANES*BEATS signed channels: registered adder tree, group accumulator, output register.
// Define ADD_CHANNEL_SAT_EN to clip the result to OUT_WIDTH (otherwise it wraps).
module add_channel_pipe
  import add_channel_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int LANES     = 16,
  parameter int BEATS     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*BIT_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_sat
);

  localparam int LEVELS = clog2(LANES);
  localparam int TW     = BIT_WIDTH + LEVELS;
  localparam int ACC_W  = acc_width(BIT_WIDTH, LANES, BEATS);
  localparam int CNT_W  = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [TW-1:0]           tree_out;
  logic                    tree_vld;
  logic signed [ACC_W-1:0] tree_ext;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    fin_d, fin_q;

  logic [OUT_WIDTH-1:0]    out_data_d, out_data_q;
  logic                    out_sat_d, out_sat_q;
  logic                    out_valid_q;

  // Every stage freezes while a result is waiting on the consumer.
  assign in_ready = !(out_valid_q && !out_ready);

  genvar gi;
  for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int IW    = BIT_WIDTH + gi;
    localparam int PAIRS = LANES >> (gi + 1);

    logic [2*PAIRS*IW-1:0]    lvl_in;
    logic                     lvl_vin;
    logic [PAIRS*(IW+1)-1:0]  lvl_out;
    logic                     lvl_vout;

    if (gi == 0) begin : g_src
      assign lvl_in  = in_data;
      assign lvl_vin = in_valid;
    end else begin : g_chain
      assign lvl_in  = g_lvl[gi-1].lvl_out;
      assign lvl_vin = g_lvl[gi-1].lvl_vout;
    end

    add_tree_level #(
      .IN_WIDTH (IW),
      .PAIRS    (PAIRS)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (in_ready),
      .valid_i (lvl_vin),
      .data_i  (lvl_in),
      .valid_o (lvl_vout),
      .data_o  (lvl_out)
    );

    if (gi == LEVELS - 1) begin : g_sink
      assign tree_out = lvl_out;
      assign tree_vld = lvl_vout;
    end
  end

  assign tree_ext = ACC_W'($signed(tree_out));

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    fin_d = 1'b0;
    if (tree_vld) begin
      acc_d = (cnt_q == '0) ? tree_ext : acc_q + tree_ext;
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        fin_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
    end else if (in_ready) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      fin_q <= fin_d;
    end
  end

`ifdef ADD_CHANNEL_SAT_EN
  sat_res_t sat_res;
  assign sat_res    = saturate(64'(acc_q), OUT_WIDTH);
  assign out_data_d = OUT_WIDTH'(sat_res.val);
  assign out_sat_d  = sat_res.sat;
`else
  assign out_data_d = OUT_WIDTH'(acc_q);
  assign out_sat_d  = 1'b0;
`endif

  // A handshake and a freshly completed group on the same edge keep out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= fin_q;
      if (fin_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
